lfsr_req_scheduler: RTL and testbench



---
 rtl/lfsr_pkg.sv | 41 ++++
 rtl/lfsr_core.sv | 42 ++++
 rtl/lfsr_req_scheduler.sv | 145 ++++++++++++++
 tb/tb_lfsr_req_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_pkg
// Description : Shared types, constants and round-robin helper for the
//               LFSR request scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_STEP = 2'd2,
        S_RESP = 2'd3
    } state_e;

    localparam logic [31:0] DEFAULT_TAPS = 32'h80200003;
    localparam logic [31:0] DEFAULT_SEED = 32'h00000001;
    localparam int          MAX_REQ      = 8;

    // First set bit at or after ptr, wrapping modulo n (n <= MAX_REQ).
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [2:0]         ptr,
                                           input int                 n);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = 3'd0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = (int'(ptr) + i) % n;
            if (!found && (i < n) && req[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_core.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_core
// Description : Right-shifting Galois LFSR with load; zero seeds become 1.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_core #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = 32'h80200003,
    parameter logic [WIDTH-1:0] SEED  = 32'h00000001
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = (load_value == '0) ? C_ONE : load_value;
        end else if (en) begin
            q_d = q_q[0] ? ((q_q >> 1) ^ TAPS) : (q_q >> 1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) q_q <= SEED;
        else       q_q <= q_d;
    end

    assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/lfsr_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_req_scheduler
// Description : Round-robin arbiter sharing one Galois LFSR among N_REQ
//               requesters, with seed sequencing and idle free-run.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_req_scheduler
    import lfsr_pkg::*;
#(
    parameter int               N_REQ        = 4,
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] TAPS         = 32'h80200003,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = 32'h00000001
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] rsp_valid,
    input  logic [N_REQ-1:0] rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    input  logic             seed_wr,
    input  logic [WIDTH-1:0] seed_value,
    input  logic             free_run,
    output logic             busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic               busy_q, busy_d;
    logic               pend_q, pend_d;
    logic [WIDTH-1:0]   pend_val_q, pend_val_d;

    logic               lfsr_en;
    logic               lfsr_load;
    logic [WIDTH-1:0]   lfsr_q;
    logic [MAX_REQ-1:0] req_ext;
    logic [2:0]         ptr_ext;
    logic [2:0]         pick;
    logic [PTR_W-1:0]   ptr_next;

    always_comb begin
        req_ext               = '0;
        req_ext[N_REQ-1:0]    = req;
        ptr_ext               = '0;
        ptr_ext[PTR_W-1:0]    = ptr_q;
        pick                  = rr_pick(req_ext, ptr_ext, N_REQ);
        ptr_next              = (grant_q == PTR_W'(N_REQ - 1)) ? '0 : grant_q + PTR_W'(1);
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        rsp_valid_d = '0;
        pend_d      = pend_q;
        pend_val_d  = pend_val_q;
        lfsr_en     = 1'b0;
        lfsr_load   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A strobe in this very cycle still beats a waiting request.
                if (pend_q || seed_wr) begin
                    state_d = S_LOAD;
                end else if (|req) begin
                    grant_d = pick[PTR_W-1:0];
                    state_d = S_STEP;
                end else begin
                    lfsr_en = free_run;
                end
            end
            S_LOAD: begin
                lfsr_load = 1'b1;
                pend_d    = 1'b0;
                state_d   = S_IDLE;
            end
            S_STEP: begin
                lfsr_en              = 1'b1;
                rsp_valid_d[grant_q] = 1'b1;
                state_d              = S_RESP;
            end
            S_RESP: begin
                // Handshake or abandoned request both release the grant.
                if ((rsp_valid_q[grant_q] && rsp_ready[grant_q]) || !req[grant_q]) begin
                    ptr_d   = ptr_next;
                    state_d = S_IDLE;
                end else begin
                    rsp_valid_d = rsp_valid_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (seed_wr) begin
            pend_d     = 1'b1;
            pend_val_d = seed_value;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_val_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            pend_q      <= pend_d;
            pend_val_q  <= pend_val_d;
        end
    end

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED_DEFAULT)
    ) u_lfsr_core (
        .clock      (clock),
        .reset      (reset),
        .en         (lfsr_en),
        .load       (lfsr_load),
        .load_value (pend_val_q),
        .q          (lfsr_q)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = lfsr_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_req_scheduler
// Description : Self-checking bench: transaction-level reference model plus
//               directed scenarios with hand-computed LFSR values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_req_scheduler;

    localparam int          N    = 4;
    localparam logic [31:0] TAPS = 32'h80200003;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready = '0;
    logic [31:0] rsp_data;
    logic        seed_wr = 1'b0;
    logic [31:0] seed_value = '0;
    logic        free_run = 1'b0;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int          hs_g[$];
    logic [31:0] hs_d[$];
    int          hs_t[$];

    lfsr_req_scheduler #(
        .N_REQ        (N),
        .WIDTH        (32),
        .TAPS         (TAPS),
        .SEED_DEFAULT (32'h00000001)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .seed_wr    (seed_wr),
        .seed_value (seed_value),
        .free_run   (free_run),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] m_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
    endfunction

    // Reference model: phase 0 idle, 1 seed load, 2 step, 3 responding.
    int          m_phase = 0;
    int          m_g     = 0;
    int          m_ptr   = 0;
    bit          m_pend  = 0;
    logic [31:0] m_pval  = '0;
    logic [31:0] m_lfsr  = 32'h1;

    always @(posedge clock) begin : model
        bit found;
        cyc++;
        if (reset) begin
            m_phase = 0; m_ptr = 0; m_g = 0; m_pend = 0; m_pval = '0; m_lfsr = 32'h1;
        end else begin
            case (m_phase)
                0: begin
                    if (m_pend || seed_wr) m_phase = 1;
                    else if (req != 0) begin
                        found = 0;
                        for (int k = 0; k < N; k++)
                            if (!found && req[(m_ptr + k) % N]) begin
                                m_g = (m_ptr + k) % N;
                                found = 1;
                            end
                        m_phase = 2;
                    end else if (free_run) m_lfsr = m_step(m_lfsr);
                end
                1: begin
                    m_lfsr  = (m_pval == 0) ? 32'h1 : m_pval;
                    m_pend  = 0;
                    m_phase = 0;
                end
                2: begin
                    m_lfsr  = m_step(m_lfsr);
                    m_phase = 3;
                end
                default: begin
                    if (rsp_ready[m_g] || !req[m_g]) begin
                        m_phase = 0;
                        m_ptr   = (m_g + 1) % N;
                    end
                end
            endcase
            if (seed_wr) begin
                m_pend = 1;
                m_pval = seed_value;
            end
        end
    end

    always @(negedge clock) begin : compare
        logic [3:0] ev;
        ev = (m_phase == 3) ? 4'(1 << m_g) : 4'd0;
        check("rsp_valid", 32'(rsp_valid), 32'(ev));
        check("busy", 32'(busy), 32'(m_phase != 0));
        if (ev != 0) check("rsp_data", rsp_data, m_lfsr);
        if (|(rsp_valid & rsp_ready)) begin
            for (int i = 0; i < N; i++)
                if (rsp_valid[i]) hs_g.push_back(i);
            hs_d.push_back(rsp_data);
            hs_t.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; rsp_ready = '0; seed_wr = 1'b0; seed_value = '0; free_run = 1'b0;
        tick(2);
        reset = 1'b0;
        hs_g.delete(); hs_d.delete(); hs_t.delete();
    endtask

    task automatic wait_hs(input int n, input int budget);
        int c = 0;
        while (hs_g.size() < n && c < budget) begin
            tick(1);
            c++;
        end
        if (hs_g.size() < n) check("handshake_timeout", 32'(hs_g.size()), 32'(n));
    endtask

    task automatic wait_valid(input int lane, input int budget);
        int c = 0;
        while (!rsp_valid[lane] && c < budget) begin
            tick(1);
            c++;
        end
        if (!rsp_valid[lane]) check("valid_timeout", 32'(rsp_valid), 32'(1 << lane));
    endtask

    int t0;

    initial begin
        // Reset state
        do_reset();
        check("reset_valid", 32'(rsp_valid), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_lfsr", rsp_data, 32'h00000001);

        // Single requester, ready high
        rsp_ready = 4'hF; req = 4'b0001; t0 = cyc;
        wait_hs(3, 30);
        req = '0;
        check("t1_latency", 32'(hs_t[0] - t0), 32'd2);
        check("t1_d0", hs_d[0], 32'h80200003);
        check("t1_d1", hs_d[1], 32'hC0300002);
        check("t1_d2", hs_d[2], 32'h60180001);
        check("t1_g2", 32'(hs_g[2]), 32'd0);
        tick(2);

        // All requesting: round-robin order, one response per 3 cycles
        do_reset();
        rsp_ready = 4'hF; req = 4'hF;
        wait_hs(5, 40);
        req = '0;
        for (int i = 0; i < 5; i++) check("t2_grant", 32'(hs_g[i]), 32'(i % 4));
        check("t2_d3", hs_d[3], 32'hB02C0003);
        check("t2_d4", hs_d[4], 32'hD8360002);
        for (int i = 1; i < 5; i++) check("t2_spacing", 32'(hs_t[i] - hs_t[i-1]), 32'd3);
        tick(2);

        // Zero seed with simultaneous request: load wins, LFSR becomes 1
        do_reset();
        rsp_ready = 4'hF; req = 4'b0100; seed_wr = 1'b1; seed_value = '0;
        tick(1);
        seed_wr = 1'b0;
        check("t3_busy_load", 32'(busy), 32'h1);
        tick(1);
        check("t3_lfsr_after_load", rsp_data, 32'h00000001);
        wait_hs(1, 20);
        req = '0;
        check("t3_grant", 32'(hs_g[0]), 32'd2);
        check("t3_data", hs_d[0], 32'h80200003);
        tick(2);

        // Back-to-back seed writes: the latest is what ends up loaded
        do_reset();
        seed_wr = 1'b1; seed_value = 32'h000000A5;
        tick(1);
        seed_value = 32'h00001234;
        tick(1);
        seed_wr = 1'b0;
        tick(3);
        check("t4_latest_seed", rsp_data, 32'h00001234);
        rsp_ready = 4'hF; req = 4'b0010;
        wait_hs(1, 20);
        req = '0;
        check("t4_data", hs_d[0], 32'h0000091A);
        tick(2);

        // Stalled lane 1: response held, other lanes wait
        do_reset();
        rsp_ready = 4'b1101; req = 4'b1010;
        wait_valid(1, 20);
        tick(5);
        check("t5_valid_held", 32'(rsp_valid), 32'h2);
        check("t5_data_held", rsp_data, 32'h80200003);
        rsp_ready = 4'hF;
        wait_hs(2, 20);
        req = '0;
        check("t5_first", 32'(hs_g[0]), 32'd1);
        check("t5_second", 32'(hs_g[1]), 32'd3);
        tick(2);

        // Request withdrawn during response
        do_reset();
        req = 4'b1000;
        wait_valid(3, 20);
        req = '0;
        tick(1);
        check("t6_valid_cleared", 32'(rsp_valid), 32'h0);
        check("t6_idle", 32'(busy), 32'h0);
        req = 4'hF; rsp_ready = 4'hF;
        wait_hs(1, 20);
        req = '0;
        check("t6_ptr_wrapped", 32'(hs_g[0]), 32'd0);
        check("t6_data", hs_d[0], 32'hC0300002);
        tick(2);

        // Free run for 3 idle cycles: 1 -> 80200003 -> C0300002 -> 60180001,
        // then the granted step gives 300C0000 ^ TAPS = B02C0003
        do_reset();
        free_run = 1'b1;
        tick(3);
        free_run = 1'b0; req = 4'b0001; rsp_ready = 4'hF;
        wait_hs(1, 20);
        req = '0;
        check("t7_free_run_data", hs_d[0], 32'hB02C0003);
        tick(2);

        // Reset while stepping
        do_reset();
        req = 4'b0001; rsp_ready = 4'hF;
        tick(1);
        check("t8_busy_step", 32'(busy), 32'h1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0; req = '0;
        check("t8_valid", 32'(rsp_valid), 32'h0);
        check("t8_busy", 32'(busy), 32'h0);
        check("t8_lfsr", rsp_data, 32'h00000001);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
